ecg_acq_sched: RTL and testbench

Acquisition scheduler sitting in front of the input sample FIFO (DIN_FIFO_SIZE deep).
- ADC mode: generates the ACQUISITION_RATE sample tick from the system clock, requests ADC conversions and writes results into the FIFO.
- UART mode: forwards host-supplied samples into the FIFO with valid/ready flow control.
- Maintains the sample counter and sticky error flags (FIFO overrun, ADC timeout) for the control/status registers.

---
 rtl/alg_pkg.sv | 32 +++
 rtl/ecg_acq_sched_if.sv | 29 ++
 rtl/acq_tick_gen.sv | 49 ++++
 rtl/ecg_acq_sched.sv | 163 ++++++++++++++++
 tb/tb_ecg_acq_sched.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alg_pkg.sv
// alg_pkg: shared constants and types for the ECG acquisition path.
//   SYSTEM_CLK / ACQUISITION_RATE set the sample tick divider (ACQ_DIV).
//   DATA_WIDTH sets the sample width. CTR_WIDTH sets the sample counter width.
//   ADC_TIMEOUT is the longest wait, in cycles, from adc_req to adc_valid.
package alg_pkg;

  localparam int SYSTEM_CLK       = 100_000_000;
  localparam int ACQUISITION_RATE = 360;
  localparam int DATA_WIDTH       = 11;
  localparam int CTR_WIDTH        = 22;
  localparam int ADC_TIMEOUT      = 1024;

  localparam int ACQ_DIV   = SYSTEM_CLK / ACQUISITION_RATE;
  localparam int ACQ_DIV_W = $clog2(ACQ_DIV);

  typedef enum logic {
    ECG_SRC_UART = 1'b0,
    ECG_SRC_ADC  = 1'b1
  } ecg_src_t;

  // Samples are offset binary. Nothing in this path changes them.
  typedef logic [DATA_WIDTH-1:0] ecg_sample_t;
  typedef logic [CTR_WIDTH-1:0]  sample_num_t;

  typedef enum logic [1:0] {
    IDLE,
    UART_RUN,
    WAIT_TICK,
    ADC_WAIT
  } acq_state_t;

endpackage

// File: rtl/ecg_acq_sched_if.sv
// ecg_acq_sched_if: groups the signals between the scheduler and the ADC,
// the UART receiver and the input FIFO.
//   master : scheduler side. It drives adc_req, uart_ready, fifo_wr and fifo_wdata.
//   slave  : ADC/UART/FIFO side. It drives adc_valid, adc_data, uart_valid,
//            uart_data and fifo_full.
interface ecg_acq_sched_if;
  import alg_pkg::*;

  logic        adc_req;
  logic        adc_valid;
  ecg_sample_t adc_data;
  logic        uart_valid;
  logic        uart_ready;
  ecg_sample_t uart_data;
  logic        fifo_full;
  logic        fifo_wr;
  ecg_sample_t fifo_wdata;

  modport master (
    output adc_req, uart_ready, fifo_wr, fifo_wdata,
    input  adc_valid, adc_data, uart_valid, uart_data, fifo_full
  );

  modport slave (
    input  adc_req, uart_ready, fifo_wr, fifo_wdata,
    output adc_valid, adc_data, uart_valid, uart_data, fifo_full
  );

endinterface

// File: rtl/acq_tick_gen.sv
// acq_tick_gen: free-running divider that produces a registered one-cycle tick.
//   clk, rst_n : system clock and asynchronous active-low reset
//   en_i       : count enable
//   clr_i      : synchronous clear. It has priority over en_i.
//   tick_o     : high for one cycle after the count reaches DIV-1
// The count starts at 0 after a clear. The first tick therefore arrives
// DIV cycles after counting begins.
module acq_tick_gen #(
  parameter int DIV = 10,
  parameter int W   = $clog2(DIV)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == W'(DIV - 1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/ecg_acq_sched.sv
// ecg_acq_sched: acquisition scheduler that feeds the input sample FIFO.
//   clk, rst_n  : system clock and asynchronous active-low reset
//   en          : acquisition enable
//   src_sel     : source select (0 = UART, 1 = ADC). It is latched only while idle.
//   err_clr     : clears the sticky ovf and tmo flags
//   bus         : ADC request/response, UART valid/ready and FIFO write signals
//   sample_num  : acquired-sample count. It wraps at 2^CTR_WIDTH.
//   ovf, tmo    : sticky flags. ovf = sample dropped because the FIFO was full.
//                 tmo = ADC did not answer in time.
//   busy        : high whenever the FSM is not IDLE
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | disabled; latch src_sel each cycle; tick counter held at 0
// UART_RUN  | forward UART samples, at most one write every 2 cycles
// WAIT_TICK | wait for the sample tick, then pulse adc_req
// ADC_WAIT  | wait up to ADC_TIMEOUT cycles for adc_valid
module ecg_acq_sched import alg_pkg::*; #(
  parameter int SYSTEM_CLK       = alg_pkg::SYSTEM_CLK,
  parameter int ACQUISITION_RATE = alg_pkg::ACQUISITION_RATE,
  parameter int ADC_TIMEOUT      = alg_pkg::ADC_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                src_sel,
  input  logic                err_clr,
  ecg_acq_sched_if.master     bus,
  output sample_num_t         sample_num,
  output logic                ovf,
  output logic                tmo,
  output logic                busy
);

  localparam int DIV   = SYSTEM_CLK / ACQUISITION_RATE;
  localparam int DIV_W = $clog2(DIV);
  localparam int TMO_W = $clog2(ADC_TIMEOUT + 1);

  // The ADC wait must finish before the next tick, or that tick would be lost.
  generate
    if (!(ADC_TIMEOUT < DIV - 2)) begin : g_bad_timeout
      $error("ecg_acq_sched: ADC_TIMEOUT must be less than DIV-2");
    end
  endgenerate

  acq_state_t  state_q, state_d;
  ecg_src_t    src_q, src_d;
  logic [TMO_W-1:0] wait_q, wait_d;
  sample_num_t sample_num_q, sample_num_d;
  logic        ovf_q, ovf_d, tmo_q, tmo_d;
  logic        ovf_set, tmo_set;
  logic        fifo_wr_q, fifo_wr_d;
  ecg_sample_t wdata_q, wdata_d;
  logic        adc_req_c, uart_ready_c;
  logic        tick, tick_en, tick_clr;

  assign tick_en  = (state_q == WAIT_TICK) || (state_q == ADC_WAIT);
  assign tick_clr = !en || (state_q == IDLE);

  acq_tick_gen #(.DIV(DIV), .W(DIV_W)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (tick_en),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    wait_d       = wait_q;
    sample_num_d = sample_num_q;
    ovf_set      = 1'b0;
    tmo_set      = 1'b0;
    fifo_wr_d    = 1'b0;
    wdata_d      = wdata_q;
    adc_req_c    = 1'b0;
    uart_ready_c = 1'b0;

    case (state_q)
      IDLE: begin
        src_d = ecg_src_t'(src_sel);
        if (en) state_d = (src_q == ECG_SRC_ADC) ? WAIT_TICK : UART_RUN;
      end
      UART_RUN: begin
        // Blocking ready in the write cycle gives the FIFO one cycle to update full.
        uart_ready_c = en && !bus.fifo_full && !fifo_wr_q;
        if (!en) begin
          state_d = IDLE;
        end else if (uart_ready_c && bus.uart_valid) begin
          fifo_wr_d    = 1'b1;
          wdata_d      = bus.uart_data;
          sample_num_d = sample_num_q + 1'b1;
        end
      end
      WAIT_TICK: begin
        if (!en) begin
          state_d = IDLE;
        end else if (tick) begin
          adc_req_c    = 1'b1;
          wait_d       = '0;
          sample_num_d = sample_num_q + 1'b1;
          state_d      = ADC_WAIT;
        end
      end
      ADC_WAIT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (bus.adc_valid) begin
          if (bus.fifo_full) begin
            ovf_set = 1'b1;
          end else begin
            fifo_wr_d = 1'b1;
            wdata_d   = bus.adc_data;
          end
          state_d = WAIT_TICK;
        end else if (wait_q == TMO_W'(ADC_TIMEOUT - 1)) begin
          tmo_set = 1'b1;
          state_d = WAIT_TICK;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new error in the same cycle as err_clr keeps the flag set.
    ovf_d = ovf_set || (ovf_q && !err_clr);
    tmo_d = tmo_set || (tmo_q && !err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      src_q        <= ECG_SRC_UART;
      wait_q       <= '0;
      sample_num_q <= '0;
      ovf_q        <= 1'b0;
      tmo_q        <= 1'b0;
      fifo_wr_q    <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      wait_q       <= wait_d;
      sample_num_q <= sample_num_d;
      ovf_q        <= ovf_d;
      tmo_q        <= tmo_d;
      fifo_wr_q    <= fifo_wr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign bus.adc_req    = adc_req_c;
  assign bus.uart_ready = uart_ready_c;
  assign bus.fifo_wr    = fifo_wr_q;
  assign bus.fifo_wdata = wdata_q;
  assign sample_num     = sample_num_q;
  assign ovf            = ovf_q;
  assign tmo            = tmo_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_ecg_acq_sched.sv
module tb_ecg_acq_sched;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        src_sel;
  logic        err_clr;
  logic [21:0] sample_num;
  logic        ovf;
  logic        tmo;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ecg_acq_sched_if bus ();

  ecg_acq_sched #(
    .SYSTEM_CLK       (1000),
    .ACQUISITION_RATE (100),
    .ADC_TIMEOUT      (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .src_sel    (src_sel),
    .err_clr    (err_clr),
    .bus        (bus),
    .sample_num (sample_num),
    .ovf        (ovf),
    .tmo        (tmo),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Starts just after the edge on which the last request was seen. After gap
  // cycles, exactly one adc_req must be high.
  task automatic wait_req(input int gap);
    for (int i = 1; i < gap; i++) begin
      cyc();
      chk("adc_req_low", {31'd0, bus.adc_req}, 32'd0);
    end
    cyc();
    chk("adc_req_high", {31'd0, bus.adc_req}, 32'd1);
  endtask

  // One nominal ADC period, starting in the request cycle R: valid at R+3,
  // the write at R+4, and the next request at R+10.
  task automatic adc_nominal(input logic [10:0] d, input logic [21:0] n);
    cyc();
    chk("sn_after_tick", {10'd0, sample_num}, {10'd0, n});
    chk("adc_req_once", {31'd0, bus.adc_req}, 32'd0);
    cyc();
    cyc();
    bus.adc_valid = 1'b1;
    bus.adc_data  = d;
    cyc();
    bus.adc_valid = 1'b0;
    chk("adc_wr", {31'd0, bus.fifo_wr}, 32'd1);
    chk("adc_wdata", {21'd0, bus.fifo_wdata}, {21'd0, d});
    cyc();
    chk("adc_wr_single", {31'd0, bus.fifo_wr}, 32'd0);
    chk("adc_wdata_hold", {21'd0, bus.fifo_wdata}, {21'd0, d});
    wait_req(5);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    src_sel = 1'b0;
    err_clr = 1'b0;
    bus.adc_valid = 1'b0;
    bus.adc_data = '0;
    bus.uart_valid = 1'b0;
    bus.uart_data = '0;
    bus.fifo_full = 1'b0;

    // Reset state
    cyc();
    cyc();
    chk("rst_adc_req", {31'd0, bus.adc_req}, 32'd0);
    chk("rst_uart_ready", {31'd0, bus.uart_ready}, 32'd0);
    chk("rst_fifo_wr", {31'd0, bus.fifo_wr}, 32'd0);
    chk("rst_wdata", {21'd0, bus.fifo_wdata}, 32'd0);
    chk("rst_sn", {10'd0, sample_num}, 32'd0);
    chk("rst_flags", {30'd0, ovf, tmo}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // ADC nominal
    src_sel = 1'b1;
    cyc();
    en = 1'b1;
    cyc();
    chk("adc_busy", {31'd0, busy}, 32'd1);
    chk("adc_req_entry", {31'd0, bus.adc_req}, 32'd0);
    wait_req(10);
    adc_nominal(11'h400, 22'd1);
    adc_nominal(11'h401, 22'd2);
    adc_nominal(11'h402, 22'd3);

    // ADC timeout: the model stays silent
    cyc();
    chk("tmo_sn", {10'd0, sample_num}, 32'd4);
    repeat (4) cyc();
    chk("tmo_not_yet", {31'd0, tmo}, 32'd0);
    chk("tmo_busy", {31'd0, busy}, 32'd1);
    cyc();
    chk("tmo_set", {31'd0, tmo}, 32'd1);
    chk("tmo_no_wr", {31'd0, bus.fifo_wr}, 32'd0);
    wait_req(4);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("tmo_cleared", {31'd0, tmo}, 32'd0);
    chk("tmo_sn_next", {10'd0, sample_num}, 32'd5);

    // FIFO overrun
    cyc();
    cyc();
    bus.adc_valid = 1'b1;
    bus.adc_data  = 11'h123;
    bus.fifo_full = 1'b1;
    cyc();
    bus.adc_valid = 1'b0;
    chk("ovf_no_wr", {31'd0, bus.fifo_wr}, 32'd0);
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    chk("ovf_wdata_hold", {21'd0, bus.fifo_wdata}, 32'h402);
    cyc();
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);
    wait_req(5);
    cyc();
    chk("ovf_sn", {10'd0, sample_num}, 32'd6);
    cyc();
    cyc();
    bus.adc_valid = 1'b1;
    bus.adc_data  = 11'h124;
    err_clr = 1'b1;
    cyc();
    bus.adc_valid = 1'b0;
    err_clr = 1'b0;
    chk("ovf_set_wins", {31'd0, ovf}, 32'd1);
    chk("ovf_no_wr2", {31'd0, bus.fifo_wr}, 32'd0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("ovf_cleared", {31'd0, ovf}, 32'd0);
    bus.fifo_full = 1'b0;

    // Abort in ADC_WAIT; the late adc_valid must be ignored
    wait_req(5);
    cyc();
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    en = 1'b0;
    cyc();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    bus.adc_valid = 1'b1;
    bus.adc_data  = 11'h555;
    cyc();
    bus.adc_valid = 1'b0;
    chk("abort_no_wr", {31'd0, bus.fifo_wr}, 32'd0);
    chk("abort_wdata", {21'd0, bus.fifo_wdata}, 32'h402);
    chk("abort_sn_hold", {10'd0, sample_num}, 32'd7);

    // Counter wrap: preload the counter while idle
    force dut.sample_num_q = 22'h3FFFFF;
    cyc();
    release dut.sample_num_q;
    cyc();
    chk("wrap_preload", {10'd0, sample_num}, 32'h3FFFFF);
    en = 1'b1;
    cyc();
    wait_req(10);
    cyc();
    chk("wrap_zero", {10'd0, sample_num}, 32'd0);
    en = 1'b0;
    cyc();

    // UART streaming
    src_sel = 1'b0;
    cyc();
    en = 1'b1;
    bus.uart_valid = 1'b1;
    bus.uart_data  = 11'h7FF;
    cyc();
    chk("uart_ready_first", {31'd0, bus.uart_ready}, 32'd1);
    cyc();
    bus.uart_data = 11'h000;
    chk("uart_wr1", {31'd0, bus.fifo_wr}, 32'd1);
    chk("uart_data1", {21'd0, bus.fifo_wdata}, 32'h7FF);
    chk("uart_ready_gap", {31'd0, bus.uart_ready}, 32'd0);
    chk("uart_sn1", {10'd0, sample_num}, 32'd1);
    cyc();
    chk("uart_gap1", {31'd0, bus.fifo_wr}, 32'd0);
    chk("uart_hold1", {21'd0, bus.fifo_wdata}, 32'h7FF);
    chk("uart_ready_back", {31'd0, bus.uart_ready}, 32'd1);
    cyc();
    bus.uart_data = 11'h3FF;
    chk("uart_wr2", {31'd0, bus.fifo_wr}, 32'd1);
    chk("uart_data2", {21'd0, bus.fifo_wdata}, 32'h000);
    chk("uart_sn2", {10'd0, sample_num}, 32'd2);
    cyc();
    chk("uart_gap2", {31'd0, bus.fifo_wr}, 32'd0);
    cyc();
    chk("uart_wr3", {31'd0, bus.fifo_wr}, 32'd1);
    chk("uart_data3", {21'd0, bus.fifo_wdata}, 32'h3FF);
    chk("uart_sn3", {10'd0, sample_num}, 32'd3);
    bus.fifo_full = 1'b1;
    bus.uart_data = 11'h111;
    cyc();
    chk("uart_full_ready", {31'd0, bus.uart_ready}, 32'd0);
    chk("uart_full_no_wr", {31'd0, bus.fifo_wr}, 32'd0);
    cyc();
    chk("uart_full_no_wr2", {31'd0, bus.fifo_wr}, 32'd0);
    chk("uart_full_sn", {10'd0, sample_num}, 32'd3);
    bus.uart_valid = 1'b0;
    bus.fifo_full = 1'b0;

    // A source change while enabled must not switch modes
    src_sel = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("src_ignored_req", {31'd0, bus.adc_req}, 32'd0);
    end
    chk("src_ignored_ready", {31'd0, bus.uart_ready}, 32'd1);
    chk("src_ignored_busy", {31'd0, busy}, 32'd1);

    // Asynchronous reset in ADC_WAIT
    en = 1'b0;
    cyc();
    cyc();
    en = 1'b1;
    cyc();
    wait_req(10);
    cyc();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    chk("pre_rst_sn", {10'd0, sample_num}, 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_adc_req", {31'd0, bus.adc_req}, 32'd0);
    chk("arst_uart_ready", {31'd0, bus.uart_ready}, 32'd0);
    chk("arst_fifo_wr", {31'd0, bus.fifo_wr}, 32'd0);
    chk("arst_wdata", {21'd0, bus.fifo_wdata}, 32'd0);
    chk("arst_sn", {10'd0, sample_num}, 32'd0);
    chk("arst_flags", {30'd0, ovf, tmo}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    en = 1'b0;
    #10;
    rst_n = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
